// File: rtl/sd_audio_pkg.sv
// -----------------------------------------------------------------------------
// sd_audio_pkg
//   Shared types and constants for the SD audio playback path.
//
//   sched_state_t  : sector scheduler FSM states
//   SEC_BYTES      : bytes per SD sector (one ping-pong half)
//   WAV_HDR_BYTES  : length of the canonical WAV header at the start of a track
//   BUF_ADDR_W     : byte address width of the 1024-byte ping-pong RAM
// -----------------------------------------------------------------------------
package sd_audio_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_INIT,
        ST_ISSUE,
        ST_WAIT_DATA,
        ST_RECV,
        ST_NEXT,
        ST_DONE,
        ST_ERR
    } sched_state_t;

    localparam int SEC_BYTES     = 512;
    localparam int WAV_HDR_BYTES = 44;
    localparam int BUF_ADDR_W    = 10;

    // Byte index within one half; the remaining address bit selects the half.
    localparam int BYTE_IDX_W    = BUF_ADDR_W - 1;

    // True while a playback pass is in progress (card init through sector turnaround).
    function automatic logic state_is_active(input sched_state_t s);
        return (s == ST_WAIT_INIT) || (s == ST_ISSUE) || (s == ST_WAIT_DATA) ||
               (s == ST_RECV)      || (s == ST_NEXT);
    endfunction

endpackage

// File: rtl/sd_req_timer.sv
// -----------------------------------------------------------------------------
// sd_req_timer
//   Loadable down-counter that bounds how long a sector read request may wait
//   for the SD read engine to acknowledge it.
//
//   i_clk      : clock
//   i_rst      : synchronous reset, active-high
//   i_start    : load LOAD_VAL-1 and start counting (cycle the request is issued)
//   i_clear    : stop the counter (request acknowledged or abandoned)
//   o_expired  : high once LOAD_VAL cycles have elapsed since i_start; stays
//                high until i_clear or a new i_start
// -----------------------------------------------------------------------------
module sd_req_timer #(
    parameter int unsigned LOAD_VAL = 2000000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_start,
    input  logic i_clear,
    output logic o_expired
);

    localparam int CNT_W = (LOAD_VAL > 1) ? $clog2(LOAD_VAL) : 1;

    // The counter starts at LOAD_VAL-1 so that expiry is flagged during the
    // LOAD_VAL-th cycle after start and acted on at the end of that cycle.
    localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(LOAD_VAL - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_run;

    // NOTE: clocked state is updated with non-blocking assignments only, so every
    // flop samples the values from before the edge regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (i_clear) begin
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (i_start) begin
            r_cnt <= LOAD_CNT;
            r_run <= 1'b1;
        end else if (r_run && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_expired = r_run && (r_cnt == '0);

endmodule

// File: rtl/sd_play_sched.sv
// -----------------------------------------------------------------------------
// sd_play_sched
//   Playback sector scheduler. Walks a contiguous sector range, requests each
//   sector from sd_read, steers the returned 512 bytes into one half of a
//   1024-byte ping-pong RAM and throttles reads against consumer drain.
//   Entirely in the SD_clk domain.
//
//   Parameters
//     SEC_W        width of sector address / sector count
//     TIMEOUT_CYC  SD_clk cycles a read request may wait for data_come
//
//   Ports
//     SD_clk, rst            clock, synchronous active-high reset
//     init                   SD card initialised (level)
//     play                   run playback (level); rising edge latches the track
//     loop_en                restart at start_sec after the last sector
//     start_sec, num_sec     track range, sampled on play rising edge
//     read_sec, read_req     sector request to sd_read (held until data_come)
//     data_come              sd_read acknowledge, sector data follows
//     mydata, myvalid        byte stream from sd_read
//     buf_release            one-hot pulse from consumer: half i drained
//     wr_en, wr_addr, wr_data  RAM write port, {half, byte_idx}
//     half_full              half i holds an unread sector
//     playing, done, err     status
//
//   Build option
//     SD_PLAY_SCHED_SKIP_HDR_EN : when defined, bytes 0..43 of the first sector
//     of every pass are written as 8'h00 so the WAV header plays as silence.
// -----------------------------------------------------------------------------
module sd_play_sched
    import sd_audio_pkg::*;
#(
    parameter int          SEC_W       = 32,
    parameter int unsigned TIMEOUT_CYC = 2000000
) (
    input  logic             SD_clk,
    input  logic             rst,
    input  logic             init,
    input  logic             play,
    input  logic             loop_en,
    input  logic [SEC_W-1:0] start_sec,
    input  logic [SEC_W-1:0] num_sec,
    output logic [SEC_W-1:0] read_sec,
    output logic             read_req,
    input  logic             data_come,
    input  logic [7:0]       mydata,
    input  logic             myvalid,
    input  logic [1:0]       buf_release,
    output logic             wr_en,
    output logic [9:0]       wr_addr,
    output logic [7:0]       wr_data,
    output logic [1:0]       half_full,
    output logic             playing,
    output logic             done,
    output logic             err
);

    localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(SEC_BYTES - 1);
    localparam logic [BYTE_IDX_W-1:0] HDR_END   = BYTE_IDX_W'(WAV_HDR_BYTES);

    // ---------------------------------------------------------------- state
    sched_state_t r_state;
    sched_state_t w_next_state;

    logic                  r_play_d;
    logic [SEC_W-1:0]      r_start_sec;
    logic [SEC_W-1:0]      r_num_sec;
    logic [SEC_W-1:0]      r_cur_sec;
    logic [SEC_W-1:0]      r_sec_cnt;
    logic                  r_fill;
    logic [BYTE_IDX_W-1:0] r_byte_cnt;
    logic [1:0]            r_half_full;
    logic [SEC_W-1:0]      r_read_sec;
    logic                  r_read_req;
    logic                  r_wr_en;
    logic [9:0]            r_wr_addr;
    logic [7:0]            r_wr_data;

    // FSM strobes consumed by the datapath
    logic w_play_rise;
    logic w_latch;
    logic w_issue;
    logic w_got_data;
    logic w_timeout;
    logic w_last_byte;
    logic w_loop_restart;
    logic w_timer_expired;
    logic w_byte_in;
    logic w_in_hdr;
    logic [7:0] w_wr_byte;
    logic [1:0] w_set_mask;

    assign w_play_rise = play & ~r_play_d;
    assign w_byte_in   = (r_state == ST_RECV) && myvalid;

    // ---------------------------------------------------------------- timeout
    sd_req_timer #(
        .LOAD_VAL (TIMEOUT_CYC)
    ) u_req_timer (
        .i_clk     (SD_clk),
        .i_rst     (rst),
        .i_start   (w_issue),
        .i_clear   (w_got_data | w_timeout),
        .o_expired (w_timer_expired)
    );

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge SD_clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every signal driven here gets a default before the case statement;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        w_next_state   = r_state;
        w_latch        = 1'b0;
        w_issue        = 1'b0;
        w_got_data     = 1'b0;
        w_timeout      = 1'b0;
        w_last_byte    = 1'b0;
        w_loop_restart = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (w_play_rise) begin
                    w_latch      = 1'b1;
                    // num_sec is sampled this very cycle, so test the input.
                    w_next_state = (num_sec == '0) ? ST_DONE : ST_WAIT_INIT;
                end
            end

            ST_WAIT_INIT: begin
                if (!play) begin
                    w_next_state = ST_IDLE;
                end else if (init) begin
                    w_next_state = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                // Only fetch into a half the consumer has drained.
                if (!play) begin
                    w_next_state = ST_IDLE;
                end else if (!r_half_full[r_fill]) begin
                    w_issue      = 1'b1;
                    w_next_state = ST_WAIT_DATA;
                end
            end

            ST_WAIT_DATA: begin
                // play is ignored here: once requested, sd_read will deliver a
                // full sector and we must consume it.
                if (data_come) begin
                    w_got_data   = 1'b1;
                    w_next_state = ST_RECV;
                end else if (w_timer_expired) begin
                    w_timeout    = 1'b1;
                    w_next_state = ST_ERR;
                end
            end

            ST_RECV: begin
                if (myvalid && (r_byte_cnt == LAST_BYTE)) begin
                    w_last_byte  = 1'b1;
                    w_next_state = ST_NEXT;
                end
            end

            ST_NEXT: begin
                if (!play) begin
                    w_next_state = ST_IDLE;
                end else if (r_sec_cnt == r_num_sec) begin
                    if (loop_en) begin
                        w_loop_restart = 1'b1;
                        w_next_state   = ST_ISSUE;
                    end else begin
                        w_next_state   = ST_DONE;
                    end
                end else begin
                    w_next_state = ST_ISSUE;
                end
            end

            ST_DONE, ST_ERR: begin
                if (!play) begin
                    w_next_state = ST_IDLE;
                end
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------- header mute
`ifdef SD_PLAY_SCHED_SKIP_HDR_EN
    // First sector of a pass carries the WAV header; write it as silence.
    assign w_in_hdr = (r_cur_sec == r_start_sec) && (r_byte_cnt < HDR_END);
`else
    assign w_in_hdr = 1'b0;
`endif

    assign w_wr_byte = w_in_hdr ? 8'h00 : mydata;

    // Half that just received its 512th byte becomes full.
    assign w_set_mask = {w_last_byte & r_fill, w_last_byte & ~r_fill};

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge SD_clk) begin
        if (rst) begin
            r_play_d    <= 1'b0;
            r_start_sec <= '0;
            r_num_sec   <= '0;
            r_cur_sec   <= '0;
            r_sec_cnt   <= '0;
            r_fill      <= 1'b0;
            r_byte_cnt  <= '0;
            r_half_full <= 2'b00;
            r_read_sec  <= '0;
            r_read_req  <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
        end else begin
            r_play_d <= play;
            r_wr_en  <= 1'b0;

            if (w_latch) begin
                r_start_sec <= start_sec;
                r_num_sec   <= num_sec;
                r_cur_sec   <= start_sec;
                r_sec_cnt   <= '0;
                r_fill      <= 1'b0;
            end

            if (w_issue) begin
                r_read_sec <= r_cur_sec;
                r_read_req <= 1'b1;
            end else if (w_got_data || w_timeout) begin
                r_read_req <= 1'b0;
            end

            if (w_got_data) begin
                r_byte_cnt <= '0;
            end

            // One-cycle write latency from the byte strobe to the RAM port.
            if (w_byte_in) begin
                r_wr_en    <= 1'b1;
                r_wr_addr  <= {r_fill, r_byte_cnt};
                r_wr_data  <= w_wr_byte;
                r_byte_cnt <= r_byte_cnt + 1'b1;
            end

            if (w_last_byte) begin
                r_fill    <= ~r_fill;
                r_sec_cnt <= r_sec_cnt + 1'b1;
                r_cur_sec <= r_cur_sec + 1'b1;
            end

            if (w_loop_restart) begin
                r_cur_sec <= r_start_sec;
                r_sec_cnt <= '0;
            end

            // Set is OR-ed in after the release mask, so a same-cycle set wins.
            if (w_latch) begin
                r_half_full <= 2'b00;
            end else begin
                r_half_full <= (r_half_full & ~buf_release) | w_set_mask;
            end
        end
    end

    // ---------------------------------------------------------------- outputs
    assign read_sec  = r_read_sec;
    assign read_req  = r_read_req;
    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign half_full = r_half_full;
    assign playing   = state_is_active(r_state);
    assign done      = (r_state == ST_DONE);
    assign err       = (r_state == ST_ERR);

endmodule

// File: doc/sd_play_sched.md
Name: sd_play_sched

Overview:
- Playback sector scheduler for the SD audio path: walks a contiguous sector range and issues sector read requests to the SD read engine.
- Steers each returned 512-byte sector into one half of a 1024-byte ping-pong RAM and tracks which halves hold unread audio.
- Throttles SD reads against consumer drain: the WAV/DAC side releases halves as it empties them.
- Sits between sd_read and the audio RAM, entirely in the SD_clk domain; replaces ad-hoc sector sequencing in the RAM read/write control.

Parameters:
- SEC_W, 32, width of sector address and sector count.
- TIMEOUT_CYC, 2000000, SD_clk cycles allowed from read_req to data_come before error.

Ports:
- SD_clk  in  1  sole clock (25 MHz SD clock).
- rst  in  1  synchronous reset, active-high.
- init  in  1  SD card initialisation complete (level).
- play  in  1  level; high = run playback, low = stop after current sector.
- loop_en  in  1  restart at start_sec after last sector.
- start_sec  in  SEC_W  first sector of track; sampled on play rising edge.
- num_sec  in  SEC_W  track length in sectors; sampled with start_sec.
- read_sec  out  SEC_W  sector address to sd_read.
- read_req  out  1  read request to sd_read.
- data_come  in  1  sd_read acknowledge: sector data starting.
- mydata  in  8  byte from sd_read.
- myvalid  in  1  byte strobe from sd_read.
- buf_release  in  2  one-hot pulse from consumer: half i drained.
- wr_en  out  1  RAM write enable.
- wr_addr  out  10  RAM byte address {half, byte_idx[8:0]}.
- wr_data  out  8  RAM write data.
- half_full  out  2  half i holds an unread sector.
- playing  out  1  FSM not in IDLE/DONE/ERR.
- done  out  1  track finished (sticky until play low).
- err  out  1  request timeout (sticky until play low or rst).

Behaviour:
- Reset: read_sec=0, read_req=0, wr_en=0, wr_addr=0, wr_data=0, half_full=2'b00, playing=0, done=0, err=0.
- Reset state: IDLE; fill half=0; byte_cnt=0; sec_cnt=0.
- FSM states: IDLE, WAIT_INIT, ISSUE, WAIT_DATA, RECV, NEXT, DONE, ERR.
- IDLE:
  - On play rising edge: latch start_sec/num_sec; cur_sec=start_sec; sec_cnt=0; fill half=0; half_full=0.
  - Then go to WAIT_INIT, or to DONE if num_sec==0.
- WAIT_INIT: wait for init=1, then ISSUE.
- ISSUE:
  - Requires half_full[fill]==0; otherwise wait here.
  - Drive read_sec=cur_sec, read_req=1; go to WAIT_DATA.
- WAIT_DATA:
  - read_req and read_sec held stable until data_come=1.
  - Same cycle as data_come: drop read_req, clear byte_cnt, go to RECV.
  - Timeout counter cleared on entry. Reaching TIMEOUT_CYC: drop read_req, set err, go to ERR.
- RECV:
  - Each myvalid cycle: next cycle wr_en=1, wr_addr={fill,byte_cnt}, wr_data=mydata; byte_cnt++. Latency is one cycle.
  - On the 512th byte (byte_cnt==511 with myvalid): set half_full[fill]; toggle fill; sec_cnt++; cur_sec++ (wraps modulo 2^SEC_W); go to NEXT.
  - myvalid outside RECV is ignored; no write.
- NEXT, evaluated in this order:
  - play==0 -> IDLE.
  - sec_cnt==num_sec and loop_en -> cur_sec=start_sec, sec_cnt=0, go to ISSUE.
  - sec_cnt==num_sec and no loop_en -> DONE (done=1).
  - Otherwise -> ISSUE.
- play falling mid-sector: current sector completes (RECV runs to 512 bytes), then IDLE. Never abandon sd_read mid-transfer.
- play falling in ISSUE or WAIT_INIT: immediate IDLE. In WAIT_DATA: wait for data_come, finish the sector, then IDLE.
- DONE/ERR: hold until play==0, then clear done/err and go to IDLE.
- buf_release[i] clears half_full[i]. Release of an empty half is ignored.
- Same-cycle set and release of the same half: set wins (half_full=1).
- buf_release=2'b11 clears both halves.
- half_full persists through DONE so the consumer drains the tail. It is cleared only on the play rising edge or rst.
- playing=1 in WAIT_INIT, ISSUE, WAIT_DATA, RECV, NEXT.

Optional Feature:
- Macro: SD_PLAY_SCHED_SKIP_HDR_EN.
- Defined: in the first sector of each pass (cur_sec==start_sec), bytes 0..43 (WAV header) are written with wr_data=8'h00, giving silence instead of header noise. wr_en and addressing are unchanged. This repeats on every loop pass.
- Undefined: all bytes pass through unmodified.

Decomposition:
- Package sd_audio_pkg holds:
  - state enum sched_state_t;
  - SEC_BYTES=512;
  - WAV_HDR_BYTES=44;
  - BUF_ADDR_W=10.
- One natural sub-module, sd_req_timer: a loadable down-counter with clear, start and expired outputs, used for the WAIT_DATA timeout.

Test Plan:
- start_sec=100, num_sec=3, loop_en=0; model returns 512 bytes per request; consumer releases each half 50 cycles after it fills -> read_sec sequence 100,101,102; wr_addr 0..511, 512..1023, 0..511; done=1; half_full ends 2'b01 until the final release.
- Consumer never releases -> exactly two sectors read (100, 101); FSM parks in ISSUE with read_req=0 and half_full=2'b11. Release half 0 -> sector 102 issued within 2 cycles.
- loop_en=1, num_sec=2 -> read_sec 100,101,100,101,...; done stays 0.
- No data_come after request, TIMEOUT_CYC=1000 -> read_req falls and err=1 at cycle 1000. play low -> err=0, state IDLE.
- play low during byte 200 of a sector -> remaining 312 bytes still written, then IDLE with no new read_req. rst mid-RECV -> all outputs at reset values on the next cycle.
- num_sec=0 -> done=1 with no read_req. Same-cycle half_full set and buf_release on that half -> half_full stays 1.
